matrix_keypad_scan: RTL and testbench

Scanner for a 4x4 matrix keypad: drives one keypad row low at a time, samples the active-low columns, debounces and decodes a single key, and emits a 4-bit key code with a one-cycle done strobe. It is the input-side counterpart of the multiplexed 7-segment driver. The display block writes the digits one at a time; this block reads the keypad one row at a time. Its outputs feed the lock state controller's `Key_Data` / `Key_Done_Sig` inputs in place of the switch-plus-button entry.

---
 rtl/lock_pkg.sv | 31 +++
 rtl/matrix_keypad_scan_if.sv | 14 +
 rtl/sync_2ff.sv | 28 ++
 rtl/matrix_keypad_scan.sv | 184 ++++++++++++++++++
 tb/tb_matrix_keypad_scan.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad scanner and the lock controller it feeds.
package lock_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } key_state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_e;

    // Number of low (pressed) columns, saturating at 2 since "two or more" is all that matters.
    function automatic logic [1:0] low_count(input logic [NUM_COLS-1:0] col_n);
        logic [2:0] n;
        n = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            n = n + {2'b00, ~col_n[c]};
        end
        return (n > 3'd1) ? 2'd2 : n[1:0];
    endfunction

endpackage

// File: rtl/matrix_keypad_scan_if.sv
// Keypad-side and key-event signals of the matrix keypad scanner.
interface matrix_keypad_scan_if;
    import lock_pkg::*;

    logic [NUM_COLS-1:0]   Col;
    logic [NUM_ROWS-1:0]   Row;
    logic [KEY_CODE_W-1:0] Key_Data;
    logic                  Key_Done_Sig;
    logic                  Key_Held;

    modport master (input Col, output Row, Key_Data, Key_Done_Sig, Key_Held);
    modport slave  (output Col, input Row, Key_Data, Key_Done_Sig, Key_Held);

endinterface

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments let both flops sample the pre-edge values, forming a real 2-stage chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/matrix_keypad_scan.sv
// 4x4 matrix keypad scanner: row scan, per-scan decode, press/release debounce, key strobe.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module matrix_keypad_scan
    import lock_pkg::*;
#(
    parameter int SCAN_CYC           = 12500,
    parameter int DEB_SCANS          = 10,
    parameter int REPEAT_DELAY_SCANS = 500,
    parameter int REPEAT_RATE_SCANS  = 100
) (
    input logic                  Clk,
    input logic                  Rst,
    matrix_keypad_scan_if.master kp
);

    localparam int          SLOT_W  = $clog2(SCAN_CYC);
    localparam logic [7:0]  DEB_CNT = 8'(DEB_SCANS);

    if (SCAN_CYC < 4 || DEB_SCANS < 1 || DEB_SCANS > 255 ||
        REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_bad_param
        $error("matrix_keypad_scan: parameter out of range");
    end

    logic [NUM_COLS-1:0]   col_s;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [1:0]            row_q, row_d;
    logic [1:0]            hits_q, hits_d, acc_hits;
    logic [KEY_CODE_W-1:0] acc_code_q, acc_code_d;
    logic [1:0]            col_idx;
    logic [1:0]            lows;
    logic                  sample, eos;
    scan_res_e             res;

    key_state_e            state_q, state_d;
    logic [KEY_CODE_W-1:0] cand_q, cand_d;
    logic [7:0]            cnt_q, cnt_d, cnt_inc;
    logic [KEY_CODE_W-1:0] key_q, key_d;
    logic                  done_q, done_d;
    logic                  accept;
`ifdef KEYPAD_REPEAT_EN
    logic [15:0]           rep_q, rep_d;
    logic                  rep_first_q, rep_first_d;
`endif

    sync_2ff #(.WIDTH(NUM_COLS), .RST_VAL({NUM_COLS{1'b1}})) u_col_sync (
        .clk (Clk),
        .rst (Rst),
        .d_i (kp.Col),
        .q_o (col_s)
    );

    assign sample = (slot_q == SLOT_W'(SCAN_CYC - 1));
    assign eos    = sample && (row_q == 2'(NUM_ROWS - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        slot_d     = sample ? '0 : slot_q + 1'b1;
        row_d      = sample ? row_q + 2'd1 : row_q;
        acc_hits   = hits_q;
        acc_code_d = acc_code_q;
        lows       = low_count(col_s);
        col_idx    = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (!col_s[c]) col_idx = 2'(c);
        end
        if (sample) begin
            if (lows == 2'd2) begin
                acc_hits = 2'd2;
            end else if (lows == 2'd1) begin
                if (hits_q == 2'd0) begin
                    acc_hits   = 2'd1;
                    acc_code_d = {row_q, col_idx};
                end else begin
                    acc_hits = 2'd2;
                end
            end
        end
        res    = (acc_hits == 2'd0) ? RES_NONE : (acc_hits == 2'd1) ? RES_SINGLE : RES_MULTI;
        hits_d = eos ? 2'd0 : acc_hits;
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        if (eos) begin
            unique case (state_q)
                IDLE: if (res == RES_SINGLE) begin
                    cand_d = acc_code_d;
                    cnt_d  = 8'd1;
                    if (DEB_SCANS == 1) accept  = 1'b1;
                    else                state_d = PRESS_DEB;
                end
                PRESS_DEB: if (res == RES_SINGLE && acc_code_d == cand_q) begin
                    cnt_d  = cnt_inc;
                    accept = (cnt_inc == DEB_CNT);
                end else if (res == RES_SINGLE) begin
                    cand_d = acc_code_d;
                    cnt_d  = 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
                HELD: if (res == RES_NONE) begin
                    cnt_d   = 8'd1;
                    state_d = (DEB_SCANS == 1) ? IDLE : RELEASE_DEB;
                end
                RELEASE_DEB: if (res == RES_NONE) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_CNT) state_d = IDLE;
                end else begin
                    state_d = HELD;
                    cnt_d   = 8'd0;
                end
                default: state_d = IDLE;
            endcase
        end
        if (accept) begin
            state_d = HELD;
            key_d   = cand_d;
            cnt_d   = 8'd0;
            done_d  = 1'b1;
        end
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        if (eos && state_q == HELD && res == RES_SINGLE && acc_code_d == key_q) begin
            rep_d = rep_q + 16'd1;
            if (rep_d == (rep_first_q ? 16'(REPEAT_RATE_SCANS) : 16'(REPEAT_DELAY_SCANS))) begin
                done_d      = 1'b1;
                rep_d       = 16'd0;
                rep_first_d = 1'b1;
            end
        end
        if (state_q == HELD && state_d != HELD) begin
            rep_d       = 16'd0;
            rep_first_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            slot_q      <= '0;
            row_q       <= '0;
            hits_q      <= '0;
            acc_code_q  <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            done_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            slot_q      <= slot_d;
            row_q       <= row_d;
            hits_q      <= hits_d;
            acc_code_q  <= eos ? '0 : acc_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            done_q      <= done_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign kp.Row          = ~(NUM_ROWS'(1) << row_q);
    assign kp.Key_Data     = key_q;
    assign kp.Key_Done_Sig = done_q;
    assign kp.Key_Held     = (state_q == HELD) || (state_q == RELEASE_DEB);

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// Scan-level bench for matrix_keypad_scan: directed vector table, reset corners, random key traffic vs a model.
module tb_matrix_keypad_scan;

    localparam int SC  = 8;
    localparam int DEB = 3;
    localparam int RD  = 5;
    localparam int RR  = 2;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] mask;
        logic        done;
        logic [3:0]  data;
        logic        held;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl[$];

    int          m_prev, m_run, m_rc;
    bit          m_held;
    logic [3:0]  m_data;

    matrix_keypad_scan_if kp();

    matrix_keypad_scan #(
        .SCAN_CYC(SC), .DEB_SCANS(DEB), .REPEAT_DELAY_SCANS(RD), .REPEAT_RATE_SCANS(RR)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Ideal keypad: a pressed key at (r,c) pulls column c low while row r is driven low.
    function automatic logic [3:0] col_of(input logic [15:0] m, input logic [3:0] row);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) c = c & ~m[r*4 +: 4];
        end
        return c;
    endfunction

    assign kp.Col = col_of(keys, kp.Row);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [15:0] m, input logic d, input logic [3:0] k, input logic h);
        vec_t v;
        v.mask = m; v.done = d; v.data = k; v.held = h;
        tbl.push_back(v);
    endtask

    // Entered at the negedge after an end-of-scan edge (or after reset release); leaves at the next one.
    task automatic run_scan(input string tag, input logic [15:0] m,
                            input logic e_done, input logic [3:0] e_data, input logic e_held);
        int stray, rowbad;
        logic [3:0] er;
        keys = m;
        stray = 0;
        rowbad = 0;
        for (int k = 1; k <= 4 * SC; k++) begin
            @(posedge clk);
            @(negedge clk);
            er = 4'hF;
            er[(k / SC) % 4] = 1'b0;
            if (kp.Row !== er) rowbad++;
            if (k < 4 * SC && kp.Key_Done_Sig !== 1'b0) stray++;
        end
        check({tag, ".row_seq_errs"}, rowbad, 0);
        check({tag, ".stray_strobes"}, stray, 0);
        check({tag, ".done"}, {31'd0, kp.Key_Done_Sig}, {31'd0, e_done});
        check({tag, ".data"}, {28'd0, kp.Key_Data}, {28'd0, e_data});
        check({tag, ".held"}, {31'd0, kp.Key_Held}, {31'd0, e_held});
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".row"}, {28'd0, kp.Row}, 32'hE);
        check({tag, ".data"}, {28'd0, kp.Key_Data}, 32'h0);
        check({tag, ".done"}, {31'd0, kp.Key_Done_Sig}, 32'h0);
        check({tag, ".held"}, {31'd0, kp.Key_Held}, 32'h0);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_prev = -1; m_run = 0; m_held = 1'b0; m_data = '0; m_rc = 0;
    endtask

    // Run-length view: a key is accepted after DEB identical single-key scans, released after DEB empty scans.
    task automatic model_scan(input logic [15:0] m, output logic e_done, output logic [3:0] e_data,
                              output logic e_held);
        int r, n;
        bit releasing;
        n = $countones(m);
        r = -1;
        if (n > 1) r = 16;
        else if (n == 1) for (int i = 0; i < 16; i++) if (m[i]) r = i;
        releasing = m_held && (m_prev == -1);
        m_run = (r == m_prev) ? m_run + 1 : 1;
        m_prev = r;
        e_done = 1'b0;
        if (!m_held) begin
            if (r >= 0 && r < 16 && m_run == DEB) begin
                m_held = 1'b1; m_data = r[3:0]; e_done = 1'b1; m_rc = 0;
            end
        end else if (r == -1) begin
            m_rc = 0;
            if (m_run == DEB) m_held = 1'b0;
        end else if (REP_ON && !releasing && r == int'(m_data)) begin
            m_rc++;
            if (m_rc == RD || (m_rc > RD && (m_rc - RD) % RR == 0)) e_done = 1'b1;
        end
        e_data = m_data;
        e_held = m_held;
    endtask

    initial begin
        logic ed, eh;
        logic [3:0] edata;
        logic [15:0] m;
        int a, b, len, kind;

        // Directed scans; held-key runs stay short so the table also holds with auto-repeat on.
        for (int i = 0; i < 2; i++) add_vec(16'h0200, 1'b0, 4'h0, 1'b0);
        add_vec(16'h0200, 1'b1, 4'h9, 1'b1);
        for (int i = 0; i < 2; i++) add_vec(16'h0200, 1'b0, 4'h9, 1'b1);
        for (int i = 0; i < 2; i++) add_vec(16'h0000, 1'b0, 4'h9, 1'b1);
        add_vec(16'h0200, 1'b0, 4'h9, 1'b1);
        for (int i = 0; i < 2; i++) add_vec(16'h0000, 1'b0, 4'h9, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h9, 1'b0);
        for (int i = 0; i < 2; i++) add_vec(16'h0200, 1'b0, 4'h9, 1'b0);
        add_vec(16'h0200, 1'b1, 4'h9, 1'b1);
        for (int i = 0; i < 2; i++) add_vec(16'h0000, 1'b0, 4'h9, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h9, 1'b0);
        for (int i = 0; i < 4; i++) add_vec((i % 2 == 0) ? 16'h0040 : 16'h0000, 1'b0, 4'h9, 1'b0);
        for (int i = 0; i < 2; i++) add_vec(16'h0040, 1'b0, 4'h9, 1'b0);
        add_vec(16'h0040, 1'b1, 4'h6, 1'b1);
        for (int i = 0; i < 2; i++) add_vec(16'h0000, 1'b0, 4'h6, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h6, 1'b0);
        for (int i = 0; i < 10; i++) add_vec(16'h0009, 1'b0, 4'h6, 1'b0);
        add_vec(16'h0001, 1'b0, 4'h6, 1'b0);
        for (int i = 0; i < 2; i++) add_vec(16'h0008, 1'b0, 4'h6, 1'b0);
        add_vec(16'h0008, 1'b1, 4'h3, 1'b1);
        add_vec(16'h0001, 1'b0, 4'h3, 1'b1);
        for (int i = 0; i < 2; i++) add_vec(16'h0000, 1'b0, 4'h3, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h3, 1'b0);

        // Power-on reset held three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("por.row", {28'd0, kp.Row}, 32'hE);
        check("por.data", {28'd0, kp.Key_Data}, 32'h0);
        check("por.done", {31'd0, kp.Key_Done_Sig}, 32'h0);
        check("por.held", {31'd0, kp.Key_Held}, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) run_scan($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].done, tbl[i].data, tbl[i].held);

        // Reset in the middle of a press debounce, then a fresh three-scan acceptance.
        for (int i = 0; i < 2; i++) run_scan("mid_pd", 16'h0200, 1'b0, 4'h3, 1'b0);
        do_reset("mid_rst");
        for (int i = 0; i < 2; i++) run_scan("post_rst", 16'h0200, 1'b0, 4'h0, 1'b0);
        run_scan("post_rst.acc", 16'h0200, 1'b1, 4'h9, 1'b1);

        // Hold 12 scans past acceptance: repeats at 5, 7, 9, 11 only when auto-repeat is built in.
        for (int i = 1; i <= 12; i++)
            run_scan($sformatf("hold%0d", i), 16'h0200,
                     REP_ON && (i == 5 || i == 7 || i == 9 || i == 11), 4'h9, 1'b1);
        for (int i = 0; i < 2; i++) run_scan("hold_rel", 16'h0000, 1'b0, 4'h9, 1'b1);
        run_scan("hold_rel.end", 16'h0000, 1'b0, 4'h9, 1'b0);

        // Random key traffic against the scan-level model.
        do_reset("rand_rst");
        model_reset();
        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            m = '0;
            if (kind == 1 || kind == 2) m[a] = 1'b1;
            if (kind == 3) begin m[a] = 1'b1; m[b] = 1'b1; end
            len = $urandom_range(1, 8);
            for (int s = 0; s < len; s++) begin
                model_scan(m, ed, edata, eh);
                run_scan($sformatf("rand%0d_%0d", seg, s), m, ed, edata, eh);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
